// File: rtl/counter_seq_arbiter.sv
// Two-requester arbiter that turns step commands into up/down pulses for a shared mod-4 counter.
// Round-robin on ties, with an optional idle gap between pulses; pos shadows the counter value.
module counter_seq_arbiter #(
  parameter int STEP_GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic       a_dir,
  input  logic [3:0] a_steps,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic       b_dir,
  input  logic [3:0] b_steps,
  output logic       b_ready,
  output logic       up,
  output logic       down,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic [1:0] pos
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

  localparam logic [3:0] GAP_LAST = (STEP_GAP > 0) ? 4'(STEP_GAP - 1) : 4'd0;

  state_t     state, state_nxt;
  logic       dir_q;
  logic       owner;
  logic       last_b;
  logic [3:0] rem;
  logic [3:0] gap_cnt;
  logic [1:0] pos_q;
  logic       grant_a, grant_b;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    up        = 1'b0;
    down      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        grant_a = a_valid && (!b_valid || last_b);
        grant_b = b_valid && (!a_valid || !last_b);
        if (grant_a)      state_nxt = (a_steps != 4'd0) ? ISSUE : DONE;
        else if (grant_b) state_nxt = (b_steps != 4'd0) ? ISSUE : DONE;
      end
      ISSUE: begin
        up   = dir_q;
        down = !dir_q;
        if (rem == 4'd1)        state_nxt = DONE;
        else if (STEP_GAP == 0) state_nxt = ISSUE;
        else                    state_nxt = GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = ISSUE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Outputs are held quiet for the whole reset cycle, not just after the edge.
    if (!rst) begin
      grant_a   = 1'b0;
      grant_b   = 1'b0;
      up        = 1'b0;
      down      = 1'b0;
      done      = 1'b0;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_q   <= 2'd0;
      rem     <= 4'd0;
      last_b  <= 1'b1;
      dir_q   <= 1'b0;
      owner   <= 1'b0;
      gap_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_a) begin
            dir_q <= a_dir;
            rem   <= a_steps;
            owner <= 1'b0;
          end else if (grant_b) begin
            dir_q <= b_dir;
            rem   <= b_steps;
            owner <= 1'b1;
          end
        end
        ISSUE: begin
          rem     <= rem - 4'd1;
          pos_q   <= dir_q ? pos_q + 2'd1 : pos_q - 2'd1;
          gap_cnt <= 4'd0;
        end
        GAP:     gap_cnt <= gap_cnt + 4'd1;
        DONE:    last_b  <= owner;
        default: ;
      endcase
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign busy    = rst && (state != IDLE);
  assign done_id = owner;
  assign pos     = pos_q;

endmodule

// File: tb/tb_counter_seq_arbiter.sv
// Directed bench: a vector table on a STEP_GAP=1 instance, plus hand sequences for
// mid-command reset abort and back-to-back pulses on a STEP_GAP=0 instance.
module tb_counter_seq_arbiter;

  logic       clk;
  logic       rst;
  logic       a_valid, a_dir, b_valid, b_dir;
  logic [3:0] a_steps, b_steps;
  logic       a_ready, b_ready, up, down, busy, done, done_id;
  logic [1:0] pos;

  logic       z_valid, z_dir;
  logic [3:0] z_steps;
  logic       z_ready, zb_ready, z_up, z_down, z_busy, z_done, z_done_id;
  logic [1:0] z_pos;

  int checks   = 0;
  int failures = 0;

  counter_seq_arbiter #(.STEP_GAP(1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_dir(a_dir), .a_steps(a_steps), .a_ready(a_ready),
    .b_valid(b_valid), .b_dir(b_dir), .b_steps(b_steps), .b_ready(b_ready),
    .up(up), .down(down), .busy(busy), .done(done), .done_id(done_id), .pos(pos)
  );

  counter_seq_arbiter #(.STEP_GAP(0)) dut_g0 (
    .clk(clk), .rst(rst),
    .a_valid(z_valid), .a_dir(z_dir), .a_steps(z_steps), .a_ready(z_ready),
    .b_valid(1'b0), .b_dir(1'b0), .b_steps(4'd0), .b_ready(zb_ready),
    .up(z_up), .down(z_down), .busy(z_busy), .done(z_done), .done_id(z_done_id), .pos(z_pos)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       r;
    logic       av, ad;
    logic [3:0] as;
    logic       bv, bd;
    logic [3:0] bs;
    logic [8:0] exp;  // {a_ready, b_ready, up, down, busy, done, done_id, pos}
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic av, input logic ad, input logic [3:0] as,
                              input logic bv, input logic bd, input logic [3:0] bs,
                              input logic ar, input logic br, input logic eu, input logic ed,
                              input logic eb, input logic edn, input logic eid, input logic [1:0] ep);
    vec_t v;
    v.r = r; v.av = av; v.ad = ad; v.as = as; v.bv = bv; v.bd = bd; v.bs = bs;
    v.exp = {ar, br, eu, ed, eb, edn, eid, ep};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_dir = 0; a_steps = 0;
    b_valid = 0; b_dir = 0; b_steps = 0;
  endtask

  logic [8:0] act;
  int         up_cnt;

  initial begin
    rst = 1'b0;
    idle_inputs();
    z_valid = 0; z_dir = 0; z_steps = 0;

    // r  av ad as  bv bd bs | ar br up dn by dn id pos
    vq.push_back(mk(0, 0,0,4'd0, 0,0,4'd0, 0,0,0,0,0,0,0,2'd0)); // reset state
    vq.push_back(mk(1, 1,1,4'd5, 0,0,4'd0, 1,0,0,0,0,0,0,2'd0)); // A up x5 accepted
    vq.push_back(mk(1, 0,0,4'd0, 0,0,4'd0, 0,0,1,0,1,0,0,2'd0));
    vq.push_back(mk(1, 0,0,4'd0, 1,0,4'd3, 0,0,0,0,1,0,0,2'd1)); // B ignored while busy
    vq.push_back(mk(1, 0,0,4'd0, 0,0,4'd0, 0,0,1,0,1,0,0,2'd1));
    vq.push_back(mk(1, 0,0,4'd0, 0,0,4'd0, 0,0,0,0,1,0,0,2'd2));
    vq.push_back(mk(1, 0,0,4'd0, 0,0,4'd0, 0,0,1,0,1,0,0,2'd2));
    vq.push_back(mk(1, 0,0,4'd0, 0,0,4'd0, 0,0,0,0,1,0,0,2'd3));
    vq.push_back(mk(1, 0,0,4'd0, 0,0,4'd0, 0,0,1,0,1,0,0,2'd3));
    vq.push_back(mk(1, 0,0,4'd0, 0,0,4'd0, 0,0,0,0,1,0,0,2'd0)); // wrapped 3 -> 0
    vq.push_back(mk(1, 0,0,4'd0, 0,0,4'd0, 0,0,1,0,1,0,0,2'd0));
    vq.push_back(mk(1, 0,0,4'd0, 0,0,4'd0, 0,0,0,0,1,1,0,2'd1)); // done, owner A
    vq.push_back(mk(1, 0,0,4'd0, 0,0,4'd0, 0,0,0,0,0,0,0,2'd1));
    vq.push_back(mk(0, 0,0,4'd0, 0,0,4'd0, 0,0,0,0,0,0,0,2'd1)); // reset cycle
    vq.push_back(mk(1, 0,0,4'd0, 1,0,4'd1, 0,1,0,0,0,0,0,2'd0)); // B down x1
    vq.push_back(mk(1, 0,0,4'd0, 0,0,4'd0, 0,0,0,1,1,0,0,2'd0));
    vq.push_back(mk(1, 0,0,4'd0, 0,0,4'd0, 0,0,0,0,1,1,1,2'd3)); // wrapped 0 -> 3
    vq.push_back(mk(1, 0,0,4'd0, 0,0,4'd0, 0,0,0,0,0,0,0,2'd3));
    vq.push_back(mk(1, 1,1,4'd0, 0,0,4'd0, 1,0,0,0,0,0,0,2'd3)); // zero steps
    vq.push_back(mk(1, 0,0,4'd0, 0,0,4'd0, 0,0,0,0,1,1,0,2'd3));
    vq.push_back(mk(1, 0,0,4'd0, 0,0,4'd0, 0,0,0,0,0,0,0,2'd3));
    vq.push_back(mk(0, 0,0,4'd0, 0,0,4'd0, 0,0,0,0,0,0,0,2'd3)); // reset cycle
    vq.push_back(mk(1, 1,1,4'd1, 1,0,4'd1, 1,0,0,0,0,0,0,2'd0)); // tie: A first
    vq.push_back(mk(1, 1,1,4'd1, 1,0,4'd1, 0,0,1,0,1,0,0,2'd0));
    vq.push_back(mk(1, 1,1,4'd1, 1,0,4'd1, 0,0,0,0,1,1,0,2'd1));
    vq.push_back(mk(1, 1,1,4'd1, 1,0,4'd1, 0,1,0,0,0,0,0,2'd1)); // B right after done
    vq.push_back(mk(1, 1,1,4'd1, 1,0,4'd1, 0,0,0,1,1,0,0,2'd1));
    vq.push_back(mk(1, 1,1,4'd1, 1,0,4'd1, 0,0,0,0,1,1,1,2'd0));
    vq.push_back(mk(1, 1,1,4'd1, 1,0,4'd1, 1,0,0,0,0,0,0,2'd0)); // back to A
    vq.push_back(mk(1, 1,1,4'd1, 1,0,4'd1, 0,0,1,0,1,0,0,2'd0));
    vq.push_back(mk(1, 0,0,4'd0, 0,0,4'd0, 0,0,0,0,1,1,0,2'd1));
    vq.push_back(mk(1, 0,0,4'd0, 0,0,4'd0, 0,0,0,0,0,0,0,2'd1));

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].r;
      a_valid = vq[i].av; a_dir = vq[i].ad; a_steps = vq[i].as;
      b_valid = vq[i].bv; b_dir = vq[i].bd; b_steps = vq[i].bs;
      #2;
      act = {a_ready, b_ready, up, down, busy, done, done ? done_id : 1'b0, pos};
      check($sformatf("vec%0d", i), 32'(act), 32'(vq[i].exp));
    end

    // Reset landing on the third pulse of an 8-step up command.
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #2 check("abort_pre_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    a_valid = 1; a_dir = 1; a_steps = 4'd8;
    #2 check("abort_accept", 32'(a_ready), 32'd1);
    up_cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      a_valid = 0;
      if (c == 5) rst = 1'b0;
      #2;
      if (up) up_cnt++;
      check($sformatf("abort_up_c%0d", c), 32'(up), (c < 5 && (c % 2 == 1)) ? 32'd1 : 32'd0);
    end
    check("abort_pulses_before", 32'(up_cnt), 32'd2);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rst = 1'b1;
      #2;
      check($sformatf("abort_quiet_c%0d", c), 32'({up, down, busy, done}), 32'd0);
      check($sformatf("abort_pos_c%0d", c), 32'(pos), 32'd0);
    end

    // STEP_GAP = 0: four consecutive up pulses, busy for five cycles.
    @(negedge clk);
    z_valid = 1; z_dir = 1; z_steps = 4'd4;
    #2 check("g0_accept", 32'(z_ready), 32'd1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      z_valid = 0;
      #2;
      check($sformatf("g0_c%0d", c), 32'({z_up, z_down, z_busy, z_done}),
            32'({(c <= 4), 1'b0, (c <= 5), (c == 5)}));
      if (c == 3) check("g0_pos_mid", 32'(z_pos), 32'd2);
      if (c == 5) check("g0_done_id", 32'(z_done_id), 32'd0);
    end
    check("g0_pos_end", 32'(z_pos), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_seq_arbiter.md
COUNTER_SEQ_ARBITER -- requirements
Module: counter_seq_arbiter

Interface
REQ-001 Parameter STEP_GAP, default 1, number of idle cycles between consecutive step pulses (legal 0..15).
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 a_valid  input  1  requester A command valid.
REQ-005 a_dir  input  1  requester A direction: 1 = up, 0 = down.
REQ-006 a_steps  input  4  requester A step count, 0..15.
REQ-007 a_ready  output  1  requester A command accepted this cycle when high with a_valid.
REQ-008 b_valid, b_dir, b_steps, b_ready: same widths and meaning as the A signals, for requester B.
REQ-009 up  output  1  single-cycle increment pulse to the shared mod-4 up/down counter.
REQ-010 down  output  1  single-cycle decrement pulse to the shared counter.
REQ-011 busy  output  1  high while a command is in progress (any state except IDLE).
REQ-012 done  output  1  one-cycle pulse when the active command completes.
REQ-013 done_id  output  1  owner of the completed command (0 = A, 1 = B), valid while done is high.
REQ-014 pos  output  2  shadow position of the shared counter, modulo 4.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, GAP and DONE.
REQ-016 In IDLE, the block SHALL assert ready combinationally to exactly one valid requester: the only valid one, or on a tie, the one not served last.
REQ-017 The last-served flag SHALL reset to B, so A wins the first tie.
REQ-018 A handshake (valid and ready high at a rising edge) SHALL latch dir, steps and owner; ready SHALL be low in every state other than IDLE.
REQ-019 After acceptance with steps > 0, the next state SHALL be ISSUE; with steps = 0, DONE (no pulses issued).
REQ-020 In ISSUE, exactly one of up/down SHALL be high for one cycle (up if dir = 1), and the remaining count SHALL decrement.
REQ-021 After ISSUE: if the remaining count reaches 0, go to DONE; else if STEP_GAP = 0, stay in ISSUE; else go to GAP.
REQ-022 GAP SHALL last exactly STEP_GAP cycles, then return to ISSUE.
REQ-023 DONE SHALL last one cycle with done = 1 and done_id = owner, update last-served to owner, then go to IDLE.
REQ-024 The first pulse SHALL occur in the cycle after the handshake.
REQ-025 A command of N steps SHALL hold busy for N + (N-1)*STEP_GAP + 1 cycles (N >= 1), or 1 cycle for N = 0.
REQ-026 pos SHALL update at the edge ending each pulse: +1 mod 4 for up, -1 mod 4 for down (3 + 1 wraps to 0; 0 - 1 wraps to 3).
REQ-027 up and down SHALL never be high in the same cycle; both SHALL be low outside ISSUE.
REQ-028 Requester inputs SHALL be ignored while busy; a requester held valid through a command SHALL be considered again in the next IDLE cycle.
REQ-029 Acceptance SHALL be possible in the IDLE cycle immediately following DONE (back-to-back commands).

Reset
REQ-030 While rst = 0 at a rising edge: state = IDLE, pos = 0, remaining count = 0, last-served = B.
REQ-031 During reset, up, down, done, busy, a_ready and b_ready SHALL be 0.
REQ-032 Reset asserted mid-command SHALL abort the command with no done pulse and no further up/down pulses from the next cycle.

Verification
REQ-033 Reset, then A: valid, dir = 1, steps = 5, STEP_GAP = 1 -> up pulses on cycles 1, 3, 5, 7, 9 after the handshake; done on cycle 10 with done_id = 0; pos = 1 (wrap 3 -> 0 -> 1).
REQ-034 From pos = 0, B: dir = 0, steps = 1 -> a single down pulse; pos = 3; done_id = 1.
REQ-035 A and B valid in the same cycle after reset -> A granted first, B granted in the first IDLE cycle after A's done; alternation repeats while both are held valid.
REQ-036 steps = 0 -> no up/down pulse; done the cycle after the handshake; pos unchanged.
REQ-037 Reset asserted on the third pulse of an 8-step up command -> pulses stop, pos = 0, busy = 0, no done pulse.
REQ-038 STEP_GAP = 0, steps = 4, dir = 1 -> up high for 4 consecutive cycles; busy for 5 cycles; pos returns to its starting value.
